// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit saturating counters and jump flag,
// combinational lookup, ID-stage update, and saturating mispredict counter.
module branch_target_buffer #(
   parameter int         XLEN     = 32,
   parameter int         ENTRIES  = 16,
   parameter logic [1:0] CTR_INIT = 2'b01,
   parameter int         CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [XLEN-1:0]  lookup_pc_i,
   output logic             pred_hit_o,
   output logic             pred_taken_o,
   output logic [XLEN-1:0]  pred_target_o,
   input  logic             upd_valid_i,
   input  logic [XLEN-1:0]  upd_pc_i,
   input  logic             upd_is_branch_i,
   input  logic             upd_taken_i,
   input  logic [XLEN-1:0]  upd_target_i,
   input  logic             upd_pred_taken_i,
   input  logic [XLEN-1:0]  upd_pred_target_i,
   input  logic             inval_all_i,
   output logic             mispredict_o,
   output logic [CNT_W-1:0] mispredict_cnt_o
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - 2 - IDX_W;

   logic [ENTRIES-1:0] valid;
   logic [ENTRIES-1:0] is_jump;
   logic [TAG_W-1:0]   tag    [ENTRIES];
   logic [XLEN-1:0]    target [ENTRIES];
   logic [1:0]         ctr    [ENTRIES];

   logic [IDX_W-1:0] l_idx, u_idx;
   logic [TAG_W-1:0] l_tag, u_tag;
   logic             u_hit;
   logic             unused;

   assign unused = ^upd_pc_i[1:0];
   assign l_idx  = lookup_pc_i[IDX_W+1:2];
   assign l_tag  = lookup_pc_i[XLEN-1:IDX_W+2];
   assign u_idx  = upd_pc_i[IDX_W+1:2];
   assign u_tag  = upd_pc_i[XLEN-1:IDX_W+2];
   assign u_hit  = valid[u_idx] && tag[u_idx] == u_tag;

   always_comb begin
      pred_hit_o    = valid[l_idx] && tag[l_idx] == l_tag;
      pred_taken_o  = pred_hit_o && (is_jump[l_idx] || ctr[l_idx][1]);
      pred_target_o = pred_taken_o ? target[l_idx] : lookup_pc_i + XLEN'(4);
      mispredict_o  = upd_valid_i && ((upd_taken_i != upd_pred_taken_i) ||
                      (upd_taken_i && upd_target_i != upd_pred_target_i));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid            <= '0;
         is_jump          <= '0;
         mispredict_cnt_o <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag[i]    <= '0;
            target[i] <= '0;
            ctr[i]    <= CTR_INIT;
         end
      end else begin
         if (mispredict_o && mispredict_cnt_o != '1)
            mispredict_cnt_o <= mispredict_cnt_o + CNT_W'(1);
         // invalidation wins over any update landing on the same edge
         if (inval_all_i)
            valid <= '0;
         else if (upd_valid_i) begin
            if (u_hit && upd_is_branch_i) begin
               ctr[u_idx] <= upd_taken_i ? (ctr[u_idx] == 2'b11 ? 2'b11 : ctr[u_idx] + 2'd1)
                                         : (ctr[u_idx] == 2'b00 ? 2'b00 : ctr[u_idx] - 2'd1);
               if (upd_taken_i)
                  target[u_idx] <= upd_target_i;
            end else if (u_hit) begin
               ctr[u_idx]     <= 2'b11;
               is_jump[u_idx] <= 1'b1;
               target[u_idx]  <= upd_target_i;
            end else if (upd_taken_i) begin
               valid[u_idx]   <= 1'b1;
               tag[u_idx]     <= u_tag;
               target[u_idx]  <= upd_target_i;
               is_jump[u_idx] <= !upd_is_branch_i;
               ctr[u_idx]     <= upd_is_branch_i ? 2'b10 : 2'b11;
            end
         end
      end
   end
endmodule
